// File: rtl/sw_score_controller_pkg.sv
// Shared definitions for the Smith-Waterman array and its job controller:
// nucleotide codes, default geometry, FSM state encoding and the log2b sizing helper.
package sw_score_controller_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_G = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_C = 2'b11;

    localparam int DEF_SCORE_WIDTH = 12;
    localparam int DEF_LENGTH      = 128;
    localparam int DEF_MAX_TARGET  = 4096;
    localparam int FLUSH_CYCLES    = 2;

    typedef enum logic [2:0] {
        ST_FLUSH  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bits needed to hold 'value' itself (128 -> 8), matching the array's sizing.
    function automatic int log2b(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) <= 64'(value)) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Biased zero score for a given score width.
    function automatic logic [31:0] zero_score(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sw_cycle_timer.sv
// Free-running cycle counter with synchronous clear and a terminal-count flag,
// used for the array flush length and the drain timeout.
module sw_cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Count up from zero after each clear, parking at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (count_r != '1) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // tc marks the last of 'limit' cycles since the clear.
    assign tc = (count_r == (limit - WIDTH'(1)));

endmodule

// File: rtl/sw_score_controller.sv
// Job sequencer for the Smith-Waterman scoring array: latches the query, streams
// target bases, waits for the array result and hands back one score per job.
module sw_score_controller
    import sw_score_controller_pkg::*;
#(
    parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
    parameter int LENGTH      = DEF_LENGTH,
    parameter int MAX_TARGET  = DEF_MAX_TARGET,
    parameter int LOG_LENGTH  = log2b(LENGTH),
    parameter int TCNT_W      = log2b(MAX_TARGET)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*LENGTH-1:0]    query_in,
    input  logic [LOG_LENGTH-1:0]  query_len,
    output logic                   busy,
    input  logic [1:0]             tgt_data,
    input  logic                   tgt_valid,
    input  logic                   tgt_last,
    output logic                   tgt_ready,
    output logic                   arr_rst_n,
    output logic                   arr_en,
    output logic [1:0]             arr_data,
    output logic [2*LENGTH-1:0]    arr_query,
    output logic [LOG_LENGTH-1:0]  arr_sel,
    input  logic [SCORE_WIDTH-1:0] arr_result,
    input  logic                   arr_vld,
    output logic [SCORE_WIDTH-1:0] score_out,
    output logic                   score_err,
    output logic                   score_valid,
    input  logic                   score_ready,
    output logic [TCNT_W-1:0]      tgt_count
);

    localparam int                     TIMEOUT     = LENGTH + 8;
    localparam int                     TIMER_W     = log2b(TIMEOUT);
    localparam logic [SCORE_WIDTH-1:0] ZERO        = SCORE_WIDTH'(zero_score(SCORE_WIDTH));
    localparam logic [TCNT_W-1:0]      TCNT_MAX    = TCNT_W'(MAX_TARGET);
    localparam logic [TCNT_W-1:0]      TCNT_LAST   = TCNT_W'(MAX_TARGET - 1);
    localparam logic [TIMER_W-1:0]     FLUSH_LIMIT = TIMER_W'(FLUSH_CYCLES);
    localparam logic [TIMER_W-1:0]     DRAIN_LIMIT = TIMER_W'(TIMEOUT);

    state_t                   state_r, state_s;
    logic                     arr_en_r, arr_en_s;
    logic [1:0]               arr_data_r, arr_data_s;
    logic [2*LENGTH-1:0]      arr_query_r, arr_query_s;
    logic [LOG_LENGTH-1:0]    arr_sel_r, arr_sel_s;
    logic [SCORE_WIDTH-1:0]   score_out_r, score_out_s;
    logic                     score_err_r, score_err_s;
    logic                     score_valid_r, score_valid_s;
    logic [TCNT_W-1:0]        tgt_count_r, tgt_count_s;
    logic                     seen_beat_r, seen_beat_s;
    logic                     err_pend_r, err_pend_s;
    logic                     busy_r, tgt_ready_r, arr_rst_n_r;
    logic                     timer_clear_s, timer_tc_s;
    logic [TIMER_W-1:0]       timer_limit_s;

    // The timer restarts on every state change, so it measures time spent in the current state.
    assign timer_clear_s = (state_s != state_r);
    assign timer_limit_s = (state_r == ST_DRAIN) ? DRAIN_LIMIT : FLUSH_LIMIT;

    sw_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear_s),
        .limit (timer_limit_s),
        .tc    (timer_tc_s)
    );

    // Next-state and next-output computation for the job sequencer.
    always_comb begin
        state_s       = state_r;
        arr_en_s      = 1'b0;
        arr_data_s    = arr_data_r;
        arr_query_s   = arr_query_r;
        arr_sel_s     = arr_sel_r;
        score_out_s   = score_out_r;
        score_err_s   = score_err_r;
        score_valid_s = 1'b0;
        tgt_count_s   = tgt_count_r;
        seen_beat_s   = seen_beat_r;
        err_pend_s    = err_pend_r;
        case (state_r)
            ST_FLUSH: begin
                if (timer_tc_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    arr_query_s = query_in;
                    arr_sel_s   = query_len;
                    tgt_count_s = '0;
                    seen_beat_s = 1'b0;
                    err_pend_s  = 1'b0;
                    if (query_len == '0) begin
                        score_out_s   = ZERO;
                        score_err_s   = 1'b1;
                        score_valid_s = 1'b1;
                        state_s       = ST_DONE;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (tgt_valid && tgt_ready_r) begin
                    arr_en_s    = 1'b1;
                    arr_data_s  = tgt_data;
                    seen_beat_s = 1'b1;
                    if (tgt_count_r != TCNT_MAX) begin
                        tgt_count_s = tgt_count_r + TCNT_W'(1);
                    end else begin
                        tgt_count_s = tgt_count_r;
                    end
                    if (tgt_last) begin
                        state_s = ST_DRAIN;
                    end else if (tgt_count_r == TCNT_LAST) begin
                        // Target overran the job limit without a last marker: drain, then report error.
                        err_pend_s = 1'b1;
                        state_s    = ST_DRAIN;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end else if (seen_beat_r) begin
                    score_out_s   = ZERO;
                    score_err_s   = 1'b1;
                    score_valid_s = 1'b1;
                    state_s       = ST_DONE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (arr_vld) begin
                    score_out_s   = err_pend_r ? ZERO : arr_result;
                    score_err_s   = err_pend_r;
                    score_valid_s = 1'b1;
                    state_s       = ST_DONE;
                end else if (timer_tc_s) begin
                    score_out_s   = ZERO;
                    score_err_s   = 1'b1;
                    score_valid_s = 1'b1;
                    state_s       = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (score_ready) begin
                    score_valid_s = 1'b0;
                    state_s       = ST_FLUSH;
                end else begin
                    score_valid_s = 1'b1;
                    state_s       = ST_DONE;
                end
            end
            default: begin
                state_s = ST_FLUSH;
            end
        endcase
    end

    // State and output registers; status outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_FLUSH;
            arr_en_r      <= 1'b0;
            arr_data_r    <= 2'b00;
            arr_query_r   <= '0;
            arr_sel_r     <= '0;
            score_out_r   <= ZERO;
            score_err_r   <= 1'b0;
            score_valid_r <= 1'b0;
            tgt_count_r   <= '0;
            seen_beat_r   <= 1'b0;
            err_pend_r    <= 1'b0;
            busy_r        <= 1'b1;
            tgt_ready_r   <= 1'b0;
            arr_rst_n_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            arr_en_r      <= arr_en_s;
            arr_data_r    <= arr_data_s;
            arr_query_r   <= arr_query_s;
            arr_sel_r     <= arr_sel_s;
            score_out_r   <= score_out_s;
            score_err_r   <= score_err_s;
            score_valid_r <= score_valid_s;
            tgt_count_r   <= tgt_count_s;
            seen_beat_r   <= seen_beat_s;
            err_pend_r    <= err_pend_s;
            busy_r        <= (state_s != ST_IDLE);
            tgt_ready_r   <= (state_s == ST_STREAM);
            arr_rst_n_r   <= (state_s != ST_FLUSH);
        end
    end

    assign busy        = busy_r;
    assign tgt_ready   = tgt_ready_r;
    assign arr_rst_n   = arr_rst_n_r;
    assign arr_en      = arr_en_r;
    assign arr_data    = arr_data_r;
    assign arr_query   = arr_query_r;
    assign arr_sel     = arr_sel_r;
    assign score_out   = score_out_r;
    assign score_err   = score_err_r;
    assign score_valid = score_valid_r;
    assign tgt_count   = tgt_count_r;

endmodule

// File: tb/tb_sw_score_controller.sv
// Directed bench for sw_score_controller: stimulus pushes expected job results into a
// queue, a monitor pops and compares them on every score handshake.
module tb_sw_score_controller;

    localparam logic [11:0] ZERO = 12'h800;

    typedef struct packed {
        logic [11:0] score;
        logic        err;
        logic [12:0] cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] query_in;
    logic [7:0]   query_len;
    logic         busy;
    logic [1:0]   tgt_data;
    logic         tgt_valid;
    logic         tgt_last;
    logic         tgt_ready;
    logic         arr_rst_n;
    logic         arr_en;
    logic [1:0]   arr_data;
    logic [255:0] arr_query;
    logic [7:0]   arr_sel;
    logic [11:0]  arr_result;
    logic         arr_vld;
    logic [11:0]  score_out;
    logic         score_err;
    logic         score_valid;
    logic         score_ready;
    logic [12:0]  tgt_count;

    int           n_cmp = 0;
    int           n_bad = 0;
    exp_t         exp_q[$];
    int           en_cnt = 0;
    logic [1:0]   en_data_q[$];

    sw_score_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .query_in    (query_in),
        .query_len   (query_len),
        .busy        (busy),
        .tgt_data    (tgt_data),
        .tgt_valid   (tgt_valid),
        .tgt_last    (tgt_last),
        .tgt_ready   (tgt_ready),
        .arr_rst_n   (arr_rst_n),
        .arr_en      (arr_en),
        .arr_data    (arr_data),
        .arr_query   (arr_query),
        .arr_sel     (arr_sel),
        .arr_result  (arr_result),
        .arr_vld     (arr_vld),
        .score_out   (score_out),
        .score_err   (score_err),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .tgt_count   (tgt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_arr_rst_n"}, arr_rst_n, 1'b0);
        check({tag, "_arr_en"}, arr_en, 1'b0);
        check({tag, "_arr_data"}, arr_data, 2'b00);
        check({tag, "_arr_sel"}, arr_sel, 8'd0);
        check({tag, "_arr_query"}, arr_query, 256'd0);
        check({tag, "_score_out"}, score_out, ZERO);
        check({tag, "_score_err"}, score_err, 1'b0);
        check({tag, "_score_valid"}, score_valid, 1'b0);
        check({tag, "_tgt_ready"}, tgt_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_tgt_count"}, tgt_count, 13'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            step();
        end
        check({tag, "_idle_reached"}, busy, 1'b0);
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (score_valid) break;
            step();
        end
        check({tag, "_score_valid_seen"}, score_valid, 1'b1);
    endtask

    task automatic accept();
        score_ready = 1'b1;
        step();
        score_ready = 1'b0;
    endtask

    task automatic beat(input logic [1:0] base, input logic last);
        tgt_valid = 1'b1;
        tgt_data  = base;
        tgt_last  = last;
        step();
        tgt_valid = 1'b0;
        tgt_last  = 1'b0;
    endtask

    task automatic begin_job(input logic [255:0] q, input logic [7:0] len);
        en_cnt = 0;
        en_data_q.delete();
        query_in  = q;
        query_len = len;
        start     = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Scoreboard monitor: compare every score handshake against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && score_valid && score_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_score: got score %0h err %0b, expected none", score_out, score_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_score_out", score_out, e.score);
                check("sb_score_err", score_err, e.err);
                check("sb_tgt_count", tgt_count, e.cnt);
            end
        end
    end

    // Array-side recorder of enable pulses and the bases they carry.
    always @(negedge clk) begin
        if (arr_en) begin
            en_cnt++;
            en_data_q.push_back(arr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] t1_seq [4];
        t1_seq[0] = 2'b00; t1_seq[1] = 2'b11; t1_seq[2] = 2'b01; t1_seq[3] = 2'b10;

        rst = 1'b1; start = 1'b0; query_in = '0; query_len = 8'd0;
        tgt_data = 2'b00; tgt_valid = 1'b0; tgt_last = 1'b0;
        arr_result = 12'h000; arr_vld = 1'b0; score_ready = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        wait_idle("post_reset");

        // T1: ACGT query and ACGT target, array returns 0x808.
        exp_q.push_back('{score: 12'h808, err: 1'b0, cnt: 13'd4});
        begin_job({248'd0, 8'h9C}, 8'd4);
        check("t1_tgt_ready", tgt_ready, 1'b1);
        check("t1_arr_sel", arr_sel, 8'd4);
        check("t1_arr_query", arr_query, {248'd0, 8'h9C});
        for (int i = 0; i < 4; i++) beat(t1_seq[i], (i == 3));
        check("t1_drain_tgt_ready", tgt_ready, 1'b0);
        step();
        step();
        arr_result = 12'h808;
        arr_vld    = 1'b1;
        step();
        arr_vld    = 1'b0;
        arr_result = 12'h123;
        check("t1_score_valid", score_valid, 1'b1);
        check("t1_en_pulses", en_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < en_data_q.size()) check("t1_arr_data", en_data_q[i], t1_seq[i]);
        end
        check("t1_done_arr_sel", arr_sel, 8'd4);
        accept();
        check("t1_flush0_arr_rst_n", arr_rst_n, 1'b0);
        check("t1_flush0_score_valid", score_valid, 1'b0);
        step();
        check("t1_flush1_arr_rst_n", arr_rst_n, 1'b0);
        step();
        check("t1_flush_end_arr_rst_n", arr_rst_n, 1'b1);
        check("t1_flush_end_busy", busy, 1'b0);
        check("t1_sb_drained", exp_q.size(), 0);

        // T2: gap after the second of five beats aborts the job.
        exp_q.push_back('{score: ZERO, err: 1'b1, cnt: 13'd2});
        begin_job({246'd0, 10'h1E4}, 8'd5);
        beat(2'b01, 1'b0);
        beat(2'b10, 1'b0);
        step();
        wait_valid("t2", 10);
        check("t2_en_pulses", en_cnt, 2);
        accept();
        wait_idle("t2");
        check("t2_sb_drained", exp_q.size(), 0);

        // T3: array never reports, timeout fires 136 cycles after DRAIN entry.
        exp_q.push_back('{score: ZERO, err: 1'b1, cnt: 13'd2});
        begin_job({252'd0, 4'hB}, 8'd2);
        beat(2'b11, 1'b0);
        arr_result = 12'h9AB;
        beat(2'b10, 1'b1);
        for (int i = 0; i < 135; i++) step();
        check("t3_before_timeout_valid", score_valid, 1'b0);
        step();
        check("t3_timeout_valid", score_valid, 1'b1);
        check("t3_timeout_err", score_err, 1'b1);
        accept();
        wait_idle("t3");
        check("t3_sb_drained", exp_q.size(), 0);

        // T4: consumer stalls ten cycles while start pulses arrive.
        exp_q.push_back('{score: 12'h7FF, err: 1'b0, cnt: 13'd1});
        begin_job({254'd0, 2'b11}, 8'd1);
        beat(2'b11, 1'b1);
        arr_result = 12'h7FF;
        arr_vld    = 1'b1;
        step();
        arr_vld = 1'b0;
        query_in  = {248'd0, 8'hFF};
        query_len = 8'd3;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            step();
            check("t4_stall_valid", score_valid, 1'b1);
            check("t4_stall_score", score_out, 12'h7FF);
            check("t4_stall_arr_rst_n", arr_rst_n, 1'b1);
        end
        start = 1'b0;
        check("t4_arr_sel_held", arr_sel, 8'd1);
        check("t4_arr_query_held", arr_query, {254'd0, 2'b11});
        accept();
        check("t4_flush_arr_rst_n", arr_rst_n, 1'b0);
        wait_idle("t4");
        check("t4_sb_drained", exp_q.size(), 0);

        // T5: zero-length query returns an error result without enabling the array.
        exp_q.push_back('{score: ZERO, err: 1'b1, cnt: 13'd0});
        begin_job({248'd0, 8'h55}, 8'd0);
        wait_valid("t5", 5);
        check("t5_en_pulses", en_cnt, 0);
        accept();
        wait_idle("t5");
        check("t5_sb_drained", exp_q.size(), 0);

        // T6: reset mid-STREAM abandons the job with no score.
        score_ready = 1'b1;
        begin_job({248'd0, 8'h9C}, 8'd4);
        beat(2'b00, 1'b0);
        tgt_valid = 1'b1;
        tgt_data  = 2'b11;
        step();
        rst = 1'b1;
        step();
        check_reset_values("t6");
        tgt_valid = 1'b0;
        rst = 1'b0;
        wait_idle("t6");
        step();
        score_ready = 1'b0;
        check("t6_no_score_valid", score_valid, 1'b0);
        check("final_sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
